// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, operand forwarding and the
// mul/div stall sequencer for a five-stage pipeline.
// Build option: define HAZARD_FWD_EN to enable E/D forwarding together with
// load-use and branch stalls. When it is undefined, forwarding is off and any
// RAW dependency on E or M stalls decode instead.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_RsD,
    input  logic [4:0] i_RtD,
    input  logic [4:0] i_RsE,
    input  logic [4:0] i_RtE,
    input  logic [4:0] i_WriteRegE,
    input  logic [4:0] i_WriteRegM,
    input  logic [4:0] i_WriteRegW,
    input  logic       i_RegWriteE,
    input  logic       i_RegWriteM,
    input  logic       i_RegWriteW,
    input  logic       i_MemtoRegE,
    input  logic       i_MemtoRegM,
    input  logic       i_BranchD,
    input  logic       i_PCSrcD,
    input  logic       i_JumpD,
    input  logic       i_MdOpE,
    output logic       o_StallF,
    output logic       o_StallD,
    output logic       o_StallE,
    output logic       o_FlushD,
    output logic       o_FlushE,
    output logic       o_FlushM,
    output logic [1:0] o_ForwardAE,
    output logic [1:0] o_ForwardBE,
    output logic       o_ForwardAD,
    output logic       o_ForwardBD,
    output logic       o_MdStart,
    output logic       o_MdBusy,
    output logic       o_MdResultValid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mdState_e;

    mdState_e   mdState, mdNext;
    logic [5:0] mdCnt;
    logic       mdStart, mdStall, mdBusy, mdValid;
    logic       hazStall;
    logic [1:0] fwdAE, fwdBE;
    logic       fwdAD, fwdBD;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

`ifdef HAZARD_FWD_EN
    logic lwStall, brStall;

    // E operand bypass: the younger producer in M takes priority over W.
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (i_RegWriteM && regMatch(i_RsE, i_WriteRegM))      fwdAE = 2'b10;
        else if (i_RegWriteW && regMatch(i_RsE, i_WriteRegW)) fwdAE = 2'b01;
        if (i_RegWriteM && regMatch(i_RtE, i_WriteRegM))      fwdBE = 2'b10;
        else if (i_RegWriteW && regMatch(i_RtE, i_WriteRegW)) fwdBE = 2'b01;
    end

    // Branch compare in D can only bypass from M; E results and M loads stall.
    always_comb begin
        fwdAD   = i_RegWriteM && regMatch(i_RsD, i_WriteRegM);
        fwdBD   = i_RegWriteM && regMatch(i_RtD, i_WriteRegM);
        lwStall = i_MemtoRegE && (regMatch(i_RsD, i_RtE) || regMatch(i_RtD, i_RtE));
        brStall = i_BranchD &&
                  ((i_RegWriteE && (regMatch(i_RsD, i_WriteRegE) || regMatch(i_RtD, i_WriteRegE))) ||
                   (i_MemtoRegM && (regMatch(i_RsD, i_WriteRegM) || regMatch(i_RtD, i_WriteRegM))));
        hazStall = lwStall || brStall;
    end
`else
    logic unusedFwdIns;
    assign unusedFwdIns = ^{i_RsE, i_RtE, i_WriteRegW, i_RegWriteW,
                            i_MemtoRegE, i_MemtoRegM, i_BranchD};

    // No bypass paths: hold decode until the producer reaches W, where the
    // write-first register file resolves the remaining conflict.
    always_comb begin
        fwdAE    = 2'b00;
        fwdBE    = 2'b00;
        fwdAD    = 1'b0;
        fwdBD    = 1'b0;
        hazStall = (i_RegWriteE && (regMatch(i_RsD, i_WriteRegE) || regMatch(i_RtD, i_WriteRegE))) ||
                   (i_RegWriteM && (regMatch(i_RsD, i_WriteRegM) || regMatch(i_RtD, i_WriteRegM)));
    end
`endif

    // Mul/div state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) mdState <= IDLE;
        else          mdState <= mdNext;
    end

    // Remaining-cycle counter: loaded on start, counts down while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          mdCnt <= 6'd0;
        else if (mdStart)      mdCnt <= 6'(MD_LATENCY - 1);
        else if (mdState == RUN) mdCnt <= mdCnt - 6'd1;
        else                   mdCnt <= 6'd0;
    end

    // Mul/div next-state; the start cycle itself counts as one stall cycle.
    always_comb begin
        mdNext = mdState;
        case (mdState)
            IDLE: if (i_MdOpE) mdNext = (MD_LATENCY == 1) ? DONE : RUN;
            RUN:  if (mdCnt == 6'd1) mdNext = DONE;
            DONE: mdNext = IDLE;
            default: mdNext = IDLE;
        endcase
    end

    // Mul/div outputs decoded from state; DONE ignores a new op in E.
    always_comb begin
        mdStart = (mdState == IDLE) && i_MdOpE;
        mdStall = mdStart || (mdState == RUN);
        mdBusy  = mdStall || (mdState == DONE);
        mdValid = (mdState == DONE);
    end

    // Final stall/flush combination, forced to 0 while reset is held.
    always_comb begin
        o_StallF        = i_rst_n && (hazStall || mdStall);
        o_StallD        = o_StallF;
        o_StallE        = i_rst_n && mdStall;
        o_FlushM        = i_rst_n && mdStall;
        o_FlushE        = i_rst_n && hazStall && !mdStall;
        o_FlushD        = i_rst_n && (i_PCSrcD || i_JumpD) && !o_StallD;
        o_ForwardAE     = i_rst_n ? fwdAE : 2'b00;
        o_ForwardBE     = i_rst_n ? fwdBE : 2'b00;
        o_ForwardAD     = i_rst_n && fwdAD;
        o_ForwardBD     = i_rst_n && fwdBD;
        o_MdStart       = i_rst_n && mdStart;
        o_MdBusy        = i_rst_n && mdBusy;
        o_MdResultValid = i_rst_n && mdValid;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a MD_LATENCY=4 instance carries the
// hazard vectors, and a MD_LATENCY=1 instance shares inputs for the
// single-cycle and back-to-back mul/div case.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD, pcSrcD, jmpD, mdOpE;

    logic       sF4, sD4, sE4, fD4, fE4, fM4, aD4, bD4, st4, bz4, vl4;
    logic [1:0] aE4, bE4;
    logic       sF1, sD1, sE1, fD1, fE1, fM1, aD1, bD1, st1, bz1, vl1;
    logic [1:0] aE1, bE1;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut4 (
        .i_clk(clk), .i_rst_n(rstN), .i_RsD(rsD), .i_RtD(rtD), .i_RsE(rsE), .i_RtE(rtE),
        .i_WriteRegE(wrE), .i_WriteRegM(wrM), .i_WriteRegW(wrW),
        .i_RegWriteE(rwE), .i_RegWriteM(rwM), .i_RegWriteW(rwW),
        .i_MemtoRegE(m2rE), .i_MemtoRegM(m2rM), .i_BranchD(brD), .i_PCSrcD(pcSrcD),
        .i_JumpD(jmpD), .i_MdOpE(mdOpE),
        .o_StallF(sF4), .o_StallD(sD4), .o_StallE(sE4), .o_FlushD(fD4), .o_FlushE(fE4),
        .o_FlushM(fM4), .o_ForwardAE(aE4), .o_ForwardBE(bE4), .o_ForwardAD(aD4),
        .o_ForwardBD(bD4), .o_MdStart(st4), .o_MdBusy(bz4), .o_MdResultValid(vl4));

    pipeline_hazard_ctrl #(.MD_LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .i_RsD(rsD), .i_RtD(rtD), .i_RsE(rsE), .i_RtE(rtE),
        .i_WriteRegE(wrE), .i_WriteRegM(wrM), .i_WriteRegW(wrW),
        .i_RegWriteE(rwE), .i_RegWriteM(rwM), .i_RegWriteW(rwW),
        .i_MemtoRegE(m2rE), .i_MemtoRegM(m2rM), .i_BranchD(brD), .i_PCSrcD(pcSrcD),
        .i_JumpD(jmpD), .i_MdOpE(mdOpE),
        .o_StallF(sF1), .o_StallD(sD1), .o_StallE(sE1), .o_FlushD(fD1), .o_FlushE(fE1),
        .o_FlushM(fM1), .o_ForwardAE(aE1), .o_ForwardBE(bE1), .o_ForwardAD(aD1),
        .o_ForwardBD(bD1), .o_MdStart(st1), .o_MdBusy(bz1), .o_MdResultValid(vl1));

    // Grouped views: {StallF,StallD,StallE,FlushD,FlushE,FlushM},
    // {ForwardAE,ForwardBE,ForwardAD,ForwardBD}, {Start,StallE,FlushM,Valid,Busy}.
    logic [5:0]  hzd4, fwd4;
    logic [4:0]  md4, md1;
    logic [14:0] all4, all1;
    assign hzd4 = {sF4, sD4, sE4, fD4, fE4, fM4};
    assign fwd4 = {aE4, bE4, aD4, bD4};
    assign md4  = {st4, sE4, fM4, vl4, bz4};
    assign md1  = {st1, sE1, fM1, vl1, bz1};
    assign all4 = {hzd4, fwd4, st4, bz4, vl4};
    assign all1 = {sF1, sD1, sE1, fD1, fE1, fM1, aE1, bE1, aD1, bD1, st1, bz1, vl1};

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [4:0] exp4 [7] = '{5'b11101, 5'b01101, 5'b01101, 5'b01101, 5'b00011, 5'b00000, 5'b00000};
    logic [4:0] exp1 [7] = '{5'b11101, 5'b00011, 5'b11101, 5'b00011, 5'b11101, 5'b00011, 5'b00000};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else nPass++;
    endtask

    task automatic clearIns();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; wrE = 0; wrM = 0; wrW = 0;
        rwE = 0; rwM = 0; rwW = 0; m2rE = 0; m2rM = 0; brD = 0; pcSrcD = 0; jmpD = 0;
    endtask

    initial begin
        clearIns();
        mdOpE = 1'b1; brD = 1'b1; pcSrcD = 1'b1; rsD = 3; wrE = 3; rwE = 1'b1;
        #1;
        chk("rst_all4", 16'(all4), 16'd0);
        chk("rst_all1", 16'(all1), 16'd0);

        @(negedge clk);
        mdOpE = 1'b0; clearIns(); rstN = 1'b1;

        // Forwarding into E, M wins over W
        rsE = 5; wrM = 5; rwM = 1; wrW = 5; rwW = 1; #1;
        chk("fwdAE_M", 16'(fwd4), FWD ? 16'b10_00_00 : 16'd0);
        rsE = 0; rtE = 6; wrM = 0; wrW = 6; #1;
        chk("fwdBE_W", 16'(fwd4), FWD ? 16'b00_01_00 : 16'd0);
        rtE = 0; #1;
        chk("fwd_r0", 16'(fwd4), 16'd0);

        // Load-use: stall F/D, bubble E, E itself not held
        clearIns(); m2rE = 1; rtE = 8; rsD = 8; wrE = 8; rwE = 1; #1;
        chk("lwStall", 16'(hzd4), 16'b110010);
        pcSrcD = 1; #1;
        chk("lwStall_noFlushD", 16'(hzd4), 16'b110010);
        clearIns(); jmpD = 1; #1;
        chk("jumpFlushD", 16'(hzd4), 16'b000100);

        // Branch on E result stalls; one cycle later M result is bypassed
        clearIns(); brD = 1; rsD = 3; rwE = 1; wrE = 3; #1;
        chk("brStallE", 16'(hzd4), 16'b110010);
        rwE = 0; wrE = 0; rwM = 1; wrM = 3; #1;
        chk("brNextHzd", 16'(hzd4), FWD ? 16'b000000 : 16'b110010);
        chk("brNextFwd", 16'(fwd4), FWD ? 16'b000010 : 16'd0);

        // Register 0 never produces a dependency
        clearIns(); brD = 1; rwE = 1; m2rE = 1; rwM = 1; #1;
        chk("reg0", 16'(hzd4), 16'd0);

        // Decode RAW on M producer
        clearIns(); rsD = 7; wrM = 7; rwM = 1; #1;
        chk("rawM", 16'({hzd4, fwd4}), FWD ? 16'b000000_000010 : 16'b110010_000000);

        // Mul/div sequence, with back-to-back ops on the latency-1 instance
        clearIns();
        @(negedge clk);
        mdOpE = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) mdOpE = 1'b0;
            #1;
            chk($sformatf("md4_c%0d", c), 16'(md4), 16'(exp4[c]));
            chk($sformatf("md1_c%0d", c), 16'(md1), 16'(exp1[c]));
        end

        // Reset in the second RUN cycle abandons the sequence
        @(negedge clk);
        mdOpE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0; #1;
        chk("midRunRst", 16'(all4), 16'd0);
        mdOpE = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk($sformatf("postRst_c%0d", c), 16'({md4, md1}), 16'd0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
